// File: rtl/int_div_unit_pkg.sv
// Shared types and helpers for the RV64M iterative radix-4 divider.
package int_div_unit_pkg;
  localparam int XLEN = 64;
  localparam logic [5:0] ITER_64 = 6'd32;
  localparam logic [5:0] ITER_W  = 6'd16;

  typedef enum logic [2:0] {
    OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } div_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_ITER, ST_DONE} div_state_t;

  typedef struct packed {
    div_op_t         op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
  } div_req_t;

  function automatic logic is_signed(div_op_t op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic is_w(div_op_t op);
    return op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_rem(div_op_t op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  // Sign fix-up of magnitudes, then quotient/remainder select; W results
  // always sign-extend bit 31, unsigned W forms included.
  function automatic logic [XLEN-1:0] fix_result(div_op_t op, logic [XLEN-1:0] q,
                                                 logic [XLEN-1:0] r, logic q_neg,
                                                 logic r_neg);
    logic [XLEN-1:0] sel;
    sel = is_rem(op) ? (r_neg ? -r : r) : (q_neg ? -q : q);
    return is_w(op) ? {{32{sel[31]}}, sel[31:0]} : sel;
  endfunction
endpackage

// File: rtl/int_div_unit_if.sv
// Issue/result bundle between register-read, the divider and write-back.
interface int_div_unit_if #(
  parameter int TAG_W = 7
);
  import int_div_unit_pkg::*;

  logic            kill_i;
  logic            valid_i;
  logic            ready_o;
  div_op_t         op_i;
  logic [TAG_W-1:0] tag_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic            valid_o;
  logic [TAG_W-1:0] tag_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output kill_i, valid_i, op_i, tag_i, src1_i, src2_i,
    input  ready_o, valid_o, tag_o, result_o
  );

  modport slave (
    input  kill_i, valid_i, op_i, tag_i, src1_i, src2_i,
    output ready_o, valid_o, tag_o, result_o
  );
endinterface

// File: rtl/int_div_unit_div_radix4_step.sv
// One radix-4 restoring iteration: two shift/compare/subtract steps per call.
// Quotient bits enter at the LSB of the dividend shift register.
module div_radix4_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvd,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_nx,
  output logic [W-1:0] dvd_nx
);
  logic [W:0]   t1, t2;
  logic [W-1:0] r1;
  logic         q1, q2;

  // The partial remainder stays below the divisor, so the W+1 bit trial
  // value drops its top bit whenever the subtraction is skipped.
  always_comb begin
    t1     = {rem, dvd[W-1]};
    q1     = (t1 >= {1'b0, dvsr});
    r1     = q1 ? W'(t1 - {1'b0, dvsr}) : t1[W-1:0];
    t2     = {r1, dvd[W-2]};
    q2     = (t2 >= {1'b0, dvsr});
    rem_nx = q2 ? W'(t2 - {1'b0, dvsr}) : t2[W-1:0];
    dvd_nx = {dvd[W-3:0], q1, q2};
  end
endmodule

// File: rtl/int_div_unit.sv
// RV64M integer divider (DIV/DIVU/REM/REMU and W forms), radix-4 iterative.
// Optional DIV_EARLY_OUT_EN: skip iterations on divide-by-zero or |a| < |b|.
module int_div_unit import int_div_unit_pkg::*; #(
  parameter int TAG_W = 7
) (
  input  logic           clk_i,
  input  logic           rst_i,
  int_div_unit_if.slave  io
);
  div_state_t       state;
  div_req_t         req_q;
  logic [TAG_W-1:0] tag_q, tag_out_q;
  logic [XLEN-1:0]  rem_q, dvd_q, dvsr_q, result_q;
  logic [XLEN-1:0]  rem_nx, dvd_nx;
  logic [5:0]       cnt_q;
  logic             q_neg_q, r_neg_q, valid_q;

  logic             sgn, w_op, s1, s2, dz;
  logic [XLEN-1:0]  a_ext, b_ext, abs_a, abs_b;

  always_comb begin
    sgn   = is_signed(req_q.op);
    w_op  = is_w(req_q.op);
    a_ext = w_op ? {{32{sgn & req_q.src1[31]}}, req_q.src1[31:0]} : req_q.src1;
    b_ext = w_op ? {{32{sgn & req_q.src2[31]}}, req_q.src2[31:0]} : req_q.src2;
    s1    = sgn & a_ext[XLEN-1];
    s2    = sgn & b_ext[XLEN-1];
    abs_a = s1 ? -a_ext : a_ext;
    abs_b = s2 ? -b_ext : b_ext;
    dz    = (b_ext == '0);
  end

  div_radix4_step #(.W(XLEN)) u_step (
    .rem    (rem_q),
    .dvd    (dvd_q),
    .dvsr   (dvsr_q),
    .rem_nx (rem_nx),
    .dvd_nx (dvd_nx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else if (io.kill_i) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.valid_i) begin
            req_q <= '{op: io.op_i, src1: io.src1_i, src2: io.src2_i};
            tag_q <= io.tag_i;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          // Divide-by-zero falls out of the iteration (all-ones quotient,
          // remainder = dividend) as long as the quotient is not negated.
          q_neg_q <= (s1 ^ s2) & ~dz;
          r_neg_q <= s1;
          rem_q   <= '0;
          dvd_q   <= w_op ? {abs_a[31:0], 32'b0} : abs_a;
          dvsr_q  <= abs_b;
          cnt_q   <= w_op ? ITER_W : ITER_64;
          state   <= ST_ITER;
`ifdef DIV_EARLY_OUT_EN
          if (dz || (abs_a < abs_b)) begin
            result_q  <= fix_result(req_q.op, dz ? {XLEN{1'b1}} : {XLEN{1'b0}},
                                    abs_a, 1'b0, s1);
            tag_out_q <= tag_q;
            valid_q   <= 1'b1;
            state     <= ST_DONE;
          end
`endif
        end
        ST_ITER: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_nx;
          cnt_q <= cnt_q - 6'd1;
          // Result is registered on the last iteration so it is on the
          // outputs for the whole DONE cycle.
          if (cnt_q == 6'd1) begin
            result_q  <= fix_result(req_q.op, dvd_nx, rem_nx, q_neg_q, r_neg_q);
            tag_out_q <= tag_q;
            valid_q   <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A flush arriving during the DONE cycle still has to squash the pulse.
  assign io.valid_o  = valid_q & ~io.kill_i;
  assign io.ready_o  = (state == ST_IDLE);
  assign io.result_o = result_q;
  assign io.tag_o    = tag_out_q;
endmodule

// File: tb/tb_int_div_unit.sv
// Scoreboard bench for int_div_unit: directed RV64M corner cases, flush,
// reset and randomized ops against an arithmetic reference model.
module tb_int_div_unit;
  import int_div_unit_pkg::*;

  localparam int TAG_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_div_unit_if #(.TAG_W(TAG_W)) bus ();

  int_div_unit #(.TAG_W(TAG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus)
  );

  typedef struct {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    int               lat;
    longint           acc;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               mon_lat;
  int               checks = 0;
  int               passes = 0;
  longint           cyc = 0;
  logic [TAG_W-1:0] tag_ctr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V M semantics straight from the ISA rules.
  function automatic logic [63:0] ref_div(input div_op_t op, input logic [63:0] a,
                                          input logic [63:0] b);
    longint      sa, sb;
    int          wa, wb;
    int unsigned ua, ub;
    logic [31:0] r32;
    sa = a; sb = b;
    wa = a[31:0]; wb = b[31:0];
    ua = a[31:0]; ub = b[31:0];
    case (op)
      OP_DIVU:  return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      OP_REMU:  return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
        if (a == 64'h8000_0000_0000_0000 && sb == -1) return a;
        return sa / sb;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && sb == -1) return 64'd0;
        return sa % sb;
      end
      OP_DIVUW: r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
      OP_REMUW: r32 = (ub == 0) ? ua : ua % ub;
      OP_DIVW: begin
        if (wb == 0) r32 = 32'hFFFF_FFFF;
        else if (a[31:0] == 32'h8000_0000 && wb == -1) r32 = 32'h8000_0000;
        else r32 = wa / wb;
      end
      default: begin
        if (wb == 0) r32 = ua;
        else if (a[31:0] == 32'h8000_0000 && wb == -1) r32 = 32'd0;
        else r32 = wa % wb;
      end
    endcase
    return sext32(r32);
  endfunction

  function automatic int lat_exp(input div_op_t op, input logic [63:0] a,
                                 input logic [63:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [63:0] ea, eb, ma, mb;
    logic        sg;
    sg = is_signed(op);
    ea = is_w(op) ? (sg ? sext32(a[31:0]) : {32'd0, a[31:0]}) : a;
    eb = is_w(op) ? (sg ? sext32(b[31:0]) : {32'd0, b[31:0]}) : b;
    ma = (sg && ea[63]) ? -ea : ea;
    mb = (sg && eb[63]) ? -eb : eb;
    if (eb == 0 || ma < mb) return 2;
`endif
    return is_w(op) ? 18 : 34;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input div_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input bit expect_out);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) begin
      checks++;
      $display("FAIL ready_timeout got=0 exp=1 op=%0d", op);
      return;
    end
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.tag_i   = tag_ctr;
    bus.src1_i  = a;
    bus.src2_i  = b;
    if (expect_out) begin
      e.res = ref_div(op, a, b);
      e.tag = tag_ctr;
      e.lat = lat_exp(op, a, b);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.src1_i  = {$urandom, $urandom};
    bus.src2_i  = {$urandom, $urandom};
    tag_ctr     = tag_ctr + 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every result pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (!rst && bus.valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_valid got res=%h tag=%0d exp=no_output",
                 bus.result_o, bus.tag_o);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_lat = int'(cyc - mon_e.acc);
        if (bus.result_o === mon_e.res && bus.tag_o === mon_e.tag && mon_lat == mon_e.lat)
          passes++;
        else
          $display("FAIL op_result got res=%h tag=%0d lat=%0d exp res=%h tag=%0d lat=%0d",
                   bus.result_o, bus.tag_o, mon_lat, mon_e.res, mon_e.tag, mon_e.lat);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [63:0] a, b;
    div_op_t     op;
    bus.kill_i  = 1'b0;
    bus.valid_i = 1'b0;
    bus.op_i    = OP_DIV;
    bus.tag_i   = '0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;

    repeat (3) @(negedge clk);
    chk("reset_valid", {63'd0, bus.valid_o}, 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    chk("reset_tag", {57'd0, bus.tag_o}, 64'd0);
    chk("reset_ready", {63'd0, bus.ready_o}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    issue(OP_DIVUW, 64'hF, 64'h4, 1);
    issue(OP_REMUW, 64'hF, 64'h4, 1);
    issue(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1);
    issue(OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1);
    issue(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1);
    issue(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1);
    issue(OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 1);
    issue(OP_REMW, 64'h8000_0000, 64'hFFFF_FFFF, 1);
    issue(OP_DIVU, 64'h1234, 64'd0, 1);
    issue(OP_REMU, 64'h1234, 64'd0, 1);
    issue(OP_DIVUW, 64'd5, 64'd0, 1);
    issue(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1);
    issue(OP_REMW, 64'h1_8000_0001, 64'd0, 1);
    issue(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    issue(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    drain();

    // Flush mid-iteration: nothing may come out, unit idle next cycle.
    issue(OP_DIVU, 64'hDEAD_BEEF_0123_4567, 64'd3, 0);
    repeat (9) @(negedge clk);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    chk("ready_after_kill", {63'd0, bus.ready_o}, 64'd1);
    repeat (40) @(negedge clk);
    issue(OP_DIVU, 64'd100, 64'd7, 1);
    drain();

    // Offer coincident with a flush must not be taken.
    bus.valid_i = 1'b1;
    bus.kill_i  = 1'b1;
    bus.op_i    = OP_DIVU;
    bus.src1_i  = 64'd50;
    bus.src2_i  = 64'd5;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    chk("kill_blocks_accept", {63'd0, bus.ready_o}, 64'd1);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 500; i++) begin
      op = ($urandom_range(0, 1) != 0) ? OP_DIVU : OP_REMU;
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 31) == 0) b = 64'd0;
      issue(op, a, b, 1);
    end
    for (int i = 0; i < 500; i++) begin
      op = ($urandom_range(0, 1) != 0) ? OP_DIVUW : OP_REMUW;
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom >> $urandom_range(0, 31)};
      if ($urandom_range(0, 31) == 0) b[31:0] = 32'd0;
      issue(op, a, b, 1);
    end
    for (int i = 0; i < 100; i++) begin
      op = div_op_t'($urandom_range(0, 7));
      a  = {$urandom, $urandom} >>> 0;
      b  = {$urandom, $urandom} >> $urandom_range(0, 62);
      if ($urandom_range(0, 1) != 0) b = -b;
      issue(op, a, b, 1);
    end
    drain();

    // Reset in the middle of an operation.
    issue(OP_DIVU, 64'hFFFF_0000_FFFF_0000, 64'd9, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_valid", {63'd0, bus.valid_o}, 64'd0);
    chk("midreset_result", bus.result_o, 64'd0);
    chk("midreset_tag", {57'd0, bus.tag_o}, 64'd0);
    chk("midreset_ready", {63'd0, bus.ready_o}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/int_div_unit.md
Name: int_div_unit

Overview:
- Iterative radix-4 integer divider for the RV64M execute stage: DIV, DIVU, REM, REMU and their 32-bit "W" forms.
- Sits beside the ALU and multiplier in the execute stage.
- Accepts one operation at a time from register-read and returns a single-cycle result pulse toward write-back.
- Follows RISC-V M semantics, including divide-by-zero and overflow.

Parameters:
- XLEN, 64, operand/result width (only 64 supported).
- TAG_W, 7, width of destination tag carried alongside the operation.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- kill_i  in  1  flush: abort any in-flight or offered operation.
- valid_i  in  1  operation offered this cycle.
- ready_o  out  1  unit idle, can accept.
- op_i  in  3  div_op_t: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- tag_i  in  TAG_W  destination tag.
- src1_i  in  XLEN  dividend.
- src2_i  in  XLEN  divisor.
- valid_o  out  1  result valid, one-cycle pulse.
- tag_o  out  TAG_W  tag of the completed operation.
- result_o  out  XLEN  quotient or remainder per op.

Behaviour:
- Reset values: valid_o=0, result_o=0, tag_o=0, ready_o=1, state IDLE.
- Reset mid-operation aborts the operation with no output.
- Accept: valid_i & ready_o & !kill_i at a rising edge. Operands, op and tag are captured at that edge; inputs may change afterward.
- FSM states and transitions:
  - IDLE: on accept, go to INIT.
  - INIT (1 cycle): W ops take low 32 bits, sign- or zero-extended per signedness. Signed ops take absolute values and record the quotient sign (sign1^sign2) and remainder sign (sign1). Load the iteration counter with 16 (W) or 32 (64-bit).
  - ITER: 2 quotient bits per cycle (radix-4 restoring, with two compare/subtracts per cycle). Go to DONE when the counter reaches 0.
  - DONE (1 cycle): apply sign fix-up, select quotient or remainder. For W ops, sign-extend bit 31 of the 32-bit result (this includes DIVUW/REMUW). Drive valid_o=1 and return to IDLE.
- Latency, counted from the accept edge to the edge where valid_o is first sampled high:
  - 64-bit ops: 34 cycles.
  - W ops: 18 cycles.
  - This latency is fixed regardless of operand values (unless DIV_EARLY_OUT_EN).
- ready_o=1 only in IDLE. There is no accept in DONE; a new accept is possible the cycle after valid_o.
- Divide by zero: quotient = all ones (W: 0xFFFFFFFF sign-extended); remainder = dividend (W: low 32 bits of dividend sign-extended).
- Signed overflow:
  - 64-bit: MIN/-1 gives quotient = MIN, remainder = 0.
  - W: 0x80000000/-1 gives quotient 0xFFFFFFFF80000000, remainder 0.
- Remainder sign equals dividend sign. Quotient truncates toward zero.
- kill_i:
  - Any state: next state IDLE, valid_o suppressed (including a kill in the DONE cycle).
  - kill_i with valid_i: the operation is not accepted.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: INIT detects divisor==0, or |dividend| < |divisor| (unsigned compare of prepared operands), and jumps straight to DONE. Result is valid 2 cycles after accept: quotient 0 with remainder = dividend, or the div-by-zero values.
- Undefined: fixed latency of 34 (64-bit) or 18 (W) cycles for all operands.

Decomposition:
- Shared package holds:
  - div_op_t enum.
  - XLEN.
  - Iteration-count constants: 32 for 64-bit, 16 for W.
  - Helper function is_signed(op).
  - Helper function is_w(op).
  - Helper function is_rem(op).
- One natural sub-module, div_radix4_step: a combinational one-iteration step (partial remainder, divisor, quotient shift).

Test Plan:
- DIVUW 0x0000000F / 0x00000004 → quotient 0x3, REMUW → 0x3. valid_o exactly 18 cycles after accept.
- DIVU 0xFFFFFFFFFFFFFFFF / 0x10 → 0x0FFFFFFFFFFFFFFF; REMU → 0xF. valid_o exactly 34 cycles after accept.
- DIV -7/2 → 0xFFFFFFFFFFFFFFFD (-3); REM -7/2 → -1. DIVW 0x80000000 / 0xFFFFFFFF → 0xFFFFFFFF80000000, REMW → 0.
- Divide by zero: DIVU 0x1234 / 0 → 0xFFFFFFFFFFFFFFFF; REMU → 0x1234. DIVUW 5 / 0 → 0xFFFFFFFFFFFFFFFF.
- Kill at cycle 10 of a 64-bit DIVU → no valid_o, ready_o=1 next cycle. A following DIVU 100/7 yields 14 at 34 cycles.
- 500 random 64-bit and 500 random 32-bit unsigned ops, compared against a software model (W results sign-extended from bit 31). Reset asserted mid-op → outputs 0, ready_o=1.
